fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: width of the program counter and of the instruction-memory address.
REQ-002 Parameter INSTR_WIDTH, default 12: width of the instruction word.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  downstream not ready; hold the fetch state.
REQ-006 halt  input  1  request to stop fetching.
REQ-007 branch_en  input  1  redirect the PC to branch_target.
REQ-008 branch_target  input  ADDR_WIDTH  redirect address.
REQ-009 instr_in  input  INSTR_WIDTH  word returned combinationally by the instruction memory for addr.
REQ-010 addr  output  ADDR_WIDTH  instruction-memory address; equals the current PC, combinational from the PC register.
REQ-011 ir  output  INSTR_WIDTH  registered instruction for decode.
REQ-012 ir_pc  output  ADDR_WIDTH  address from which ir was fetched.
REQ-013 ir_valid  output  1  ir holds a live instruction.
REQ-014 halted  output  1  high while the FSM is in HALTED.
REQ-015 pc_wrap  output  1  one-cycle pulse when the PC increments from 2^ADDR_WIDTH-1 to 0.

Function
REQ-016 The FSM SHALL have three states, BOOT, RUN and HALTED; reset enters BOOT.
REQ-017 BOOT SHALL last exactly one cycle: the PC holds 0, ir_valid=0, and the next state is RUN unconditionally, ignoring all inputs.
REQ-018 In RUN, each edge SHALL evaluate the controls in priority order branch_en > halt > stall > advance.
REQ-019 Advance (RUN, no control asserted): ir<=instr_in, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
REQ-020 PC arithmetic SHALL be modulo 2^ADDR_WIDTH; pc_wrap SHALL be 1 for the cycle after the advance edge where pc was 2^ADDR_WIDTH-1, and 0 otherwise.
REQ-021 Stall (RUN): pc, ir, ir_pc and ir_valid SHALL hold their values; pc_wrap SHALL be 0.
REQ-022 Branch in RUN (or HALTED): pc<=branch_target, ir<=0, ir_valid<=0 (a one-cycle bubble), ir_pc holds, next state RUN.
REQ-023 Branch SHALL override a simultaneous stall and a simultaneous halt.
REQ-024 Halt (RUN, no branch): the next state is HALTED; pc holds; ir_valid<=0; ir and ir_pc hold.
REQ-025 Halt SHALL override a simultaneous stall.
REQ-026 HALTED: the outputs hold and halted=1; stall and halt are ignored; only branch_en or reset leaves the state.
REQ-027 An instruction SHALL be presented on ir exactly one cycle after its address appears on addr, given no stall, branch or halt on that edge.
REQ-028 branch_target SHALL be used only when branch_en=1; its value otherwise SHALL have no effect.

Reset
REQ-029 While n_reset=0, independent of clk, the block SHALL force: state=BOOT, pc=0 (so addr=0), ir=0, ir_pc=0, ir_valid=0, halted=0, pc_wrap=0.
REQ-030 Reset asserted mid-operation (any state, including during stall or halt) SHALL discard all fetch state immediately.
REQ-031 Deassertion SHALL be followed by one BOOT cycle and then normal RUN.

Verification (ADDR_WIDTH=4, INSTR_WIDTH=12, the memory model returns instr_in = 0x100+addr)
REQ-032 Release reset, no controls -> edge 1: still BOOT, ir_valid=0; edge 2: ir=0x100, ir_pc=0, addr=1, ir_valid=1; edge 3: ir=0x101, addr=2.
REQ-033 Run from pc=14 -> after the advance from 15: addr=0, pc_wrap=1 for one cycle, ir=0x10F, ir_pc=15.
REQ-034 At pc=5, assert stall for 3 cycles -> addr stays 5, ir and ir_valid are unchanged; on release, the next edge gives ir=0x105.
REQ-035 At pc=6, assert branch_en=1, branch_target=2 and stall=1 together -> next cycle: addr=2, ir_valid=0, ir=0; the following edge (no stall) gives ir=0x102, ir_pc=2.
REQ-036 At pc=9, assert halt and stall together -> halted=1, ir_valid=0, addr stays 9 for 5 cycles; then branch_en with target 0 -> halted=0, addr=0, and the next edge gives ir=0x100.
REQ-037 In RUN at pc=7, pulse n_reset low between clock edges -> outputs go to their reset values without waiting for a clock edge; after release, the sequence matches REQ-032.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch bus: control inputs from the pipeline plus instruction-memory and
// decode-side outputs of the fetch unit.
//
// Flow control: there is no separate valid/ready pair on this bus. The
// consumer's "not ready" is signalled by stall; while stall=1 (and no branch
// or halt wins priority) the producer holds ir/ir_pc/ir_valid unchanged.
// An instruction is transferred to decode on every rising edge where
// ir_valid=1 and stall=0.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH = 12
);
  logic                   stall;
  logic                   halt;
  logic                   branch_en;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [INSTR_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0]  ir_pc;
  logic                   ir_valid;
  logic                   halted;
  logic                   pc_wrap;

  // Environment side: drives controls and memory data, observes fetch outputs.
  modport master (
    output stall, halt, branch_en, branch_target, instr_in,
    input  addr, ir, ir_pc, ir_valid, halted, pc_wrap
  );

  // Fetch unit side.
  modport slave (
    input  stall, halt, branch_en, branch_target, instr_in,
    output addr, ir, ir_pc, ir_valid, halted, pc_wrap
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and a
// BOOT/RUN/HALTED control FSM. Control priority in RUN is
// branch_en > halt > stall > advance.
module fetch_unit #(
  parameter int ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH = 12
) (
  input  logic         clk,
  input  logic         n_reset,
  fetch_unit_if.slave  bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  w_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [INSTR_WIDTH-1:0] w_ir_nxt;
  logic [ADDR_WIDTH-1:0]  r_ir_pc;
  logic [ADDR_WIDTH-1:0]  w_ir_pc_nxt;
  logic                   r_ir_valid;
  logic                   w_ir_valid_nxt;
  logic                   r_pc_wrap;
  logic                   w_pc_wrap_nxt;

  // State register; reset forces BOOT immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: BOOT always moves on; branch beats halt in RUN;
  // only a branch leaves HALTED.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:   w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.branch_en)  w_state_nxt = S_RUN;
        else if (bus.halt)  w_state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (bus.branch_en)  w_state_nxt = S_RUN;
      end
      default:  w_state_nxt = S_BOOT;
    endcase
  end

  // Datapath next values per state; hold everything unless a rule updates it.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_ir_valid_nxt = r_ir_valid;
    w_pc_wrap_nxt  = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_pc_nxt       = '0;
        w_ir_valid_nxt = 1'b0;
      end
      S_RUN: begin
        if (bus.branch_en) begin
          // Redirect inserts a one-cycle bubble; ir_pc keeps the last fetch.
          w_pc_nxt       = bus.branch_target;
          w_ir_nxt       = '0;
          w_ir_valid_nxt = 1'b0;
        end else if (bus.halt) begin
          w_ir_valid_nxt = 1'b0;
        end else if (!bus.stall) begin
          w_ir_nxt       = bus.instr_in;
          w_ir_pc_nxt    = r_pc;
          w_ir_valid_nxt = 1'b1;
          w_pc_nxt       = r_pc + ADDR_WIDTH'(1);
          w_pc_wrap_nxt  = (r_pc == {ADDR_WIDTH{1'b1}});
        end
      end
      S_HALTED: begin
        if (bus.branch_en) begin
          w_pc_nxt       = bus.branch_target;
          w_ir_nxt       = '0;
          w_ir_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_pc_nxt       = '0;
        w_ir_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset clears all fetch state immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_pc_wrap  <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_pc_wrap  <= w_pc_wrap_nxt;
    end
  end

  assign bus.addr     = r_pc;
  assign bus.ir       = r_ir;
  assign bus.ir_pc    = r_ir_pc;
  assign bus.ir_valid = r_ir_valid;
  assign bus.pc_wrap  = r_pc_wrap;
  assign bus.halted   = (r_state == S_HALTED);
  assign o_dbg_state  = r_state;

endmodule
